// File: rtl/uart_byte_receiver.sv
// 8N1 UART byte receiver: 2-FF input synchronizer, mid-bit sampling, start-bit
// glitch rejection and framing-error detection. Only clean frames update out_byte.
module uart_byte_receiver #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] out_byte,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);

    // Fewer than 4 clocks per bit leaves no room for a meaningful mid-bit sample.
    if (CPB < 4) begin : g_cpb_check
        $error("uart_byte_receiver: CLK_FREQ/BAUD must be at least 4");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q;
    logic          rx_s_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bidx_q, bidx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    out_byte_q, out_byte_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d;

    // Sync flops reset to the idle line level so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bidx_q      <= '0;
            shift_q     <= '0;
            out_byte_q  <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bidx_q      <= bidx_d;
            shift_q     <= shift_d;
            out_byte_q  <= out_byte_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bidx_d      = bidx_q;
        shift_d     = shift_q;
        out_byte_d  = out_byte_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end

            // A start bit that is high again at its midpoint was only a glitch.
            START: begin
                if (cnt_q == CNT_HALF) begin
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        cnt_d   = '0;
                        bidx_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    shift_d[bidx_q] = rx_s_q;
                    cnt_d           = '0;
                    if (bidx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bidx_d = bidx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        out_byte_d = shift_q;
                        rx_valid_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Line held low after a bad stop bit: wait for idle before hunting again.
            BREAK: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_byte  = out_byte_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Self-checking bench for uart_byte_receiver: scoreboard of expected bytes popped
// on each rx_valid pulse, plus glitch, framing-error, mid-frame reset and latency cases.
module tb_uart_byte_receiver;

    localparam int CPB     = 16;
    localparam int LATENCY = 2 + 8 + 9 * CPB + 1;

    logic       clk;
    logic       rst_n;
    logic       uart_rx;
    logic [7:0] out_byte;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int         testsRun     = 0;
    int         testsFailed  = 0;
    int         validCount   = 0;
    int         frameErrCount = 0;
    logic       sawBusy      = 1'b0;
    logic [7:0] prevByte     = 8'h00;
    logic [7:0] expectedQ[$];

    uart_byte_receiver #(
        .CLK_FREQ(16),
        .BAUD    (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .uart_rx  (uart_rx),
        .out_byte (out_byte),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge to stay clear of the sync flop.
    task automatic waitClocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic driveBit(input logic b);
        uart_rx = b;
        waitClocks(CPB);
    endtask

    // Sends one 8N1 frame, LSB first; stopBit=0 leaves the line low afterwards.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(data[i]);
        driveBit(stopBit);
    endtask

    // Output monitor on the falling edge: scoreboard pops, exclusivity and hold checks.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevByte = out_byte;
        end else begin
            if (busy) sawBusy = 1'b1;
            if (frame_err) frameErrCount++;
            checkOutput("valid_and_err_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
            if (rx_valid) begin
                validCount++;
                if (expectedQ.size() == 0) begin
                    checkOutput("unexpected_rx_valid", 32'd1, 32'd0);
                end else begin
                    checkOutput("scoreboard_byte", {24'd0, out_byte}, {24'd0, expectedQ.pop_front()});
                end
            end else begin
                checkOutput("out_byte_hold", {24'd0, out_byte}, {24'd0, prevByte});
            end
            prevByte = out_byte;
        end
    end

    initial begin
        int baseValid;
        int baseErr;
        int latency;

        uart_rx = 1'b1;
        rst_n   = 1'b0;
        waitClocks(3);
        checkOutput("reset_out_byte", {24'd0, out_byte}, 32'h00);
        checkOutput("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        waitClocks(5);

        // Single good frame
        baseValid = validCount;
        expectedQ.push_back(8'hA5);
        applyStimulus(8'hA5, 1'b1);
        waitClocks(20);
        checkOutput("t1_valid_pulses", validCount - baseValid, 1);
        checkOutput("t1_out_byte", {24'd0, out_byte}, 32'hA5);
        checkOutput("t1_no_frame_err", frameErrCount, 0);

        // Back-to-back frames with no idle gap
        baseValid = validCount;
        expectedQ.push_back(8'h3C);
        expectedQ.push_back(8'hC3);
        applyStimulus(8'h3C, 1'b1);
        applyStimulus(8'hC3, 1'b1);
        waitClocks(20);
        checkOutput("t2_valid_pulses", validCount - baseValid, 2);
        checkOutput("t2_out_byte", {24'd0, out_byte}, 32'hC3);

        // Short low glitch must be rejected at the start-bit midpoint
        baseValid = validCount;
        baseErr   = frameErrCount;
        sawBusy   = 1'b0;
        uart_rx   = 1'b0;
        waitClocks(5);
        uart_rx   = 1'b1;
        waitClocks(30);
        checkOutput("t3_busy_seen", {31'd0, sawBusy}, 32'd1);
        checkOutput("t3_no_valid", validCount - baseValid, 0);
        checkOutput("t3_no_frame_err", frameErrCount - baseErr, 0);
        checkOutput("t3_out_byte", {24'd0, out_byte}, 32'hC3);
        checkOutput("t3_idle_after", {31'd0, busy}, 32'd0);

        // Low stop bit, line held low, then recovery
        baseValid = validCount;
        baseErr   = frameErrCount;
        applyStimulus(8'h5A, 1'b0);
        waitClocks(40);
        checkOutput("t4_frame_err_pulses", frameErrCount - baseErr, 1);
        checkOutput("t4_no_valid", validCount - baseValid, 0);
        checkOutput("t4_out_byte_kept", {24'd0, out_byte}, 32'hC3);
        checkOutput("t4_busy_in_break", {31'd0, busy}, 32'd1);
        uart_rx = 1'b1;
        waitClocks(5);
        checkOutput("t4_idle_after_release", {31'd0, busy}, 32'd0);
        expectedQ.push_back(8'h11);
        applyStimulus(8'h11, 1'b1);
        waitClocks(20);
        checkOutput("t4_recovery_byte", {24'd0, out_byte}, 32'h11);

        // Reset asserted in the middle of data bit 4 of 0xFF
        uart_rx = 1'b0;
        waitClocks(CPB);
        uart_rx = 1'b1;
        waitClocks(4 * CPB + CPB / 2);
        checkOutput("t5_busy_mid_frame", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_reset_out_byte", {24'd0, out_byte}, 32'h00);
        checkOutput("t5_reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("t5_reset_frame_err", {31'd0, frame_err}, 32'd0);
        checkOutput("t5_reset_busy", {31'd0, busy}, 32'd0);
        waitClocks(3);
        rst_n = 1'b1;
        waitClocks(5);
        expectedQ.push_back(8'h81);
        applyStimulus(8'h81, 1'b1);
        waitClocks(20);
        checkOutput("t5_next_byte", {24'd0, out_byte}, 32'h81);

        // Latency from the falling edge to rx_valid; input timing here is deterministic
        expectedQ.push_back(8'h00);
        latency = 0;
        fork
            applyStimulus(8'h00, 1'b1);
            begin
                while (rx_valid !== 1'b1 && latency < 400) begin
                    @(posedge clk);
                    #1;
                    latency++;
                end
            end
        join
        waitClocks(10);
        checkOutput("t6_latency", latency, LATENCY);
        checkOutput("t6_out_byte", {24'd0, out_byte}, 32'h00);

        checkOutput("scoreboard_drained", expectedQ.size(), 0);
        checkOutput("total_frame_err_pulses", frameErrCount, 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
